// File: rtl/l1_cache_ctrl_if.sv
// Core-side request/response and L2-side request bundle for l1_cache_ctrl.
// slave = the cache controller, master = the core/L2 side driving it.
interface l1_cache_ctrl_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int WAYS       = 4
);
   localparam int LRU_W = $clog2(WAYS);

   logic                  req_valid;
   logic                  req_ready;
   logic [1:0]            req_op;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic                  resp_valid;
   logic                  resp_hit;
   logic [LRU_W-1:0]      resp_way;
   logic                  l2_req_valid;
   logic                  l2_req_ready;
   logic                  l2_req_wr;
   logic [ADDR_WIDTH-1:0] l2_req_addr;

   modport slave (
      input  req_valid, req_op, req_addr, l2_req_ready,
      output req_ready, resp_valid, resp_hit, resp_way,
             l2_req_valid, l2_req_wr, l2_req_addr
   );

   modport master (
      output req_valid, req_op, req_addr, l2_req_ready,
      input  req_ready, resp_valid, resp_hit, resp_way,
             l2_req_valid, l2_req_wr, l2_req_addr
   );
endinterface

// File: rtl/l1_cache_ctrl.sv
// WAYS-way set-associative L1 tag/state controller: true-LRU, write-back/write-allocate,
// L2 evicts and whole-cache clear. Define L1_CACHE_STATS_EN to build the statistics counters.
module l1_cache_ctrl #(
   parameter int ADDR_WIDTH     = 32,
   parameter int SETS           = 64,
   parameter int WAYS           = 4,
   parameter int BYTE_SEL_WIDTH = 6
) (
   input  logic           clk,
   input  logic           rst_n,
   l1_cache_ctrl_if.slave bus,
   output logic [31:0]    stat_reads,
   output logic [31:0]    stat_writes,
   output logic [31:0]    stat_hits,
   output logic [31:0]    stat_misses
);
   localparam int INDEX_WIDTH = $clog2(SETS);
   localparam int TAG_WIDTH   = ADDR_WIDTH - INDEX_WIDTH - BYTE_SEL_WIDTH;
   localparam int LRU_W       = $clog2(WAYS);

   typedef enum logic [1:0] {
      OP_READ  = 2'b00,
      OP_WRITE = 2'b01,
      OP_EVICT = 2'b10,
      OP_CLEAR = 2'b11
   } op_e;

   typedef enum logic [2:0] {
      S_IDLE, S_LOOKUP, S_WB, S_FILL, S_RESP, S_CLEAR
   } state_e;

   state_e                 r_state;
   state_e                 w_next;
   op_e                    r_op;
   logic [TAG_WIDTH-1:0]   r_req_tag;
   logic [INDEX_WIDTH-1:0] r_index;
   logic [INDEX_WIDTH-1:0] r_set_cnt;
   logic [LRU_W-1:0]       r_way;
   logic                   r_hit;

   logic [WAYS-1:0]        r_valid [SETS];
   logic [WAYS-1:0]        r_dirty [SETS];
   logic [TAG_WIDTH-1:0]   r_tag   [SETS][WAYS];
   logic [LRU_W-1:0]       r_age   [SETS][WAYS];

   logic                   w_accept;
   logic                   w_rd_wr;
   logic                   w_hit;
   logic [LRU_W-1:0]       w_hit_way;
   logic                   w_inv_found;
   logic [LRU_W-1:0]       w_victim_way;
   logic                   w_victim_dirty;
   logic                   w_hit_dirty;
   logic                   w_touch_en;
   logic [LRU_W-1:0]       w_touch_way;
   logic                   w_unused_offset;

   assign w_accept        = (r_state == S_IDLE) && bus.req_valid;
   assign w_rd_wr         = (r_op == OP_READ) || (r_op == OP_WRITE);
   assign w_unused_offset = ^bus.req_addr[BYTE_SEL_WIDTH-1:0];

   // Tag match and victim choice for the latched set
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      w_hit        = 1'b0;
      w_hit_way    = '0;
      w_inv_found  = 1'b0;
      w_victim_way = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (!w_hit && r_valid[r_index][w] && (r_tag[r_index][w] == r_req_tag)) begin
            w_hit     = 1'b1;
            w_hit_way = LRU_W'(w);
         end
         if (!w_inv_found && !r_valid[r_index][w]) begin
            w_inv_found  = 1'b1;
            w_victim_way = LRU_W'(w);
         end
      end
      if (!w_inv_found) begin
         for (int w = 0; w < WAYS; w++) begin
            if (r_age[r_index][w] == LRU_W'(WAYS - 1)) w_victim_way = LRU_W'(w);
         end
      end
   end

   assign w_victim_dirty = r_valid[r_index][w_victim_way] && r_dirty[r_index][w_victim_way];
   assign w_hit_dirty    = r_dirty[r_index][w_hit_way];

   assign w_touch_en  = ((r_state == S_LOOKUP) && w_rd_wr && w_hit) ||
                        ((r_state == S_FILL) && bus.l2_req_ready);
   assign w_touch_way = (r_state == S_LOOKUP) ? w_hit_way : r_way;

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (bus.req_valid) w_next = (op_e'(bus.req_op) == OP_CLEAR) ? S_CLEAR : S_LOOKUP;
         end
         S_LOOKUP: begin
            if (w_rd_wr) begin
               if (w_hit)               w_next = S_RESP;
               else if (w_victim_dirty) w_next = S_WB;
               else                     w_next = S_FILL;
            end else begin
               w_next = (w_hit && w_hit_dirty) ? S_WB : S_RESP;
            end
         end
         S_WB: begin
            if (bus.l2_req_ready) w_next = (r_op == OP_EVICT) ? S_RESP : S_FILL;
         end
         S_FILL: begin
            if (bus.l2_req_ready) w_next = S_RESP;
         end
         S_RESP:  w_next = S_IDLE;
         S_CLEAR: begin
            if (r_set_cnt == INDEX_WIDTH'(SETS - 1)) w_next = S_RESP;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_op      <= OP_READ;
         r_req_tag <= '0;
         r_index   <= '0;
         r_set_cnt <= '0;
         r_way     <= '0;
         r_hit     <= 1'b0;
         // NOTE: the directory is flops, not RAM, so it is reset explicitly; ages restart as a valid permutation.
         for (int s = 0; s < SETS; s++) begin
            r_valid[s] <= '0;
            r_dirty[s] <= '0;
            for (int w = 0; w < WAYS; w++) begin
               r_tag[s][w] <= '0;
               r_age[s][w] <= LRU_W'(w);
            end
         end
      end else begin
         if (w_touch_en) begin
            for (int w = 0; w < WAYS; w++) begin
               if (LRU_W'(w) == w_touch_way)
                  r_age[r_index][w] <= '0;
               else if (r_age[r_index][w] < r_age[r_index][w_touch_way])
                  r_age[r_index][w] <= r_age[r_index][w] + 1'b1;
            end
         end

         case (r_state)
            S_IDLE: begin
               if (bus.req_valid) begin
                  r_op      <= op_e'(bus.req_op);
                  r_req_tag <= bus.req_addr[ADDR_WIDTH-1 -: TAG_WIDTH];
                  r_index   <= bus.req_addr[BYTE_SEL_WIDTH +: INDEX_WIDTH];
                  r_set_cnt <= '0;
                  r_way     <= '0;
                  r_hit     <= 1'b0;
               end
            end
            S_LOOKUP: begin
               if (w_rd_wr) begin
                  r_hit <= w_hit;
                  r_way <= w_hit ? w_hit_way : w_victim_way;
                  if (w_hit && (r_op == OP_WRITE)) r_dirty[r_index][w_hit_way] <= 1'b1;
               end else begin
                  r_hit <= w_hit;
                  r_way <= w_hit_way;
                  if (w_hit && !w_hit_dirty) r_valid[r_index][w_hit_way] <= 1'b0;
               end
            end
            S_WB: begin
               if (bus.l2_req_ready && (r_op == OP_EVICT)) begin
                  r_valid[r_index][r_way] <= 1'b0;
                  r_dirty[r_index][r_way] <= 1'b0;
               end
            end
            S_FILL: begin
               if (bus.l2_req_ready) begin
                  r_tag[r_index][r_way]   <= r_req_tag;
                  r_valid[r_index][r_way] <= 1'b1;
                  r_dirty[r_index][r_way] <= (r_op == OP_WRITE);
               end
            end
            S_CLEAR: begin
               r_valid[r_set_cnt] <= '0;
               r_dirty[r_set_cnt] <= '0;
               for (int w = 0; w < WAYS; w++) r_age[r_set_cnt][w] <= LRU_W'(w);
               r_set_cnt <= r_set_cnt + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.req_ready    = (r_state == S_IDLE);
   assign bus.resp_valid   = (r_state == S_RESP);
   assign bus.resp_hit     = (r_state == S_RESP) && r_hit;
   assign bus.resp_way     = (r_state == S_RESP) ? r_way : '0;
   assign bus.l2_req_valid = (r_state == S_WB) || (r_state == S_FILL);
   assign bus.l2_req_wr    = (r_state == S_WB);

   // Driven only from registered state, so fields hold steady while L2 stalls
   always_comb begin
      bus.l2_req_addr = '0;
      if (r_state == S_WB)
         bus.l2_req_addr = {r_tag[r_index][r_way], r_index, {BYTE_SEL_WIDTH{1'b0}}};
      else if (r_state == S_FILL)
         bus.l2_req_addr = {r_req_tag, r_index, {BYTE_SEL_WIDTH{1'b0}}};
   end

`ifdef L1_CACHE_STATS_EN
   logic [31:0] r_stat_reads;
   logic [31:0] r_stat_writes;
   logic [31:0] r_stat_hits;
   logic [31:0] r_stat_misses;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_stat_reads  <= '0;
         r_stat_writes <= '0;
         r_stat_hits   <= '0;
         r_stat_misses <= '0;
      end else if (w_accept && (op_e'(bus.req_op) == OP_CLEAR)) begin
         r_stat_reads  <= '0;
         r_stat_writes <= '0;
         r_stat_hits   <= '0;
         r_stat_misses <= '0;
      end else begin
         if (w_accept && (op_e'(bus.req_op) == OP_READ) && (r_stat_reads != '1))
            r_stat_reads <= r_stat_reads + 1'b1;
         if (w_accept && (op_e'(bus.req_op) == OP_WRITE) && (r_stat_writes != '1))
            r_stat_writes <= r_stat_writes + 1'b1;
         if ((r_state == S_LOOKUP) && w_rd_wr) begin
            if (w_hit && (r_stat_hits != '1))    r_stat_hits   <= r_stat_hits + 1'b1;
            if (!w_hit && (r_stat_misses != '1)) r_stat_misses <= r_stat_misses + 1'b1;
         end
      end
   end

   assign stat_reads  = r_stat_reads;
   assign stat_writes = r_stat_writes;
   assign stat_hits   = r_stat_hits;
   assign stat_misses = r_stat_misses;
`else
   assign stat_reads  = '0;
   assign stat_writes = '0;
   assign stat_hits   = '0;
   assign stat_misses = '0;
`endif
endmodule

// File: tb/tb_l1_cache_ctrl.sv
// Directed testbench for l1_cache_ctrl (SETS=64, WAYS=4): LRU, write-back, evict, clear, reset.
module tb_l1_cache_ctrl;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] stat_reads, stat_writes, stat_hits, stat_misses;
   int          n_cmp = 0;
   int          n_err = 0;

   l1_cache_ctrl_if #(.ADDR_WIDTH(32), .WAYS(4)) bus ();

   l1_cache_ctrl #(
      .ADDR_WIDTH(32), .SETS(64), .WAYS(4), .BYTE_SEL_WIDTH(6)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus),
      .stat_reads  (stat_reads),
      .stat_writes (stat_writes),
      .stat_hits   (stat_hits),
      .stat_misses (stat_misses)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic issue(input string tag, input logic [1:0] op, input logic [31:0] addr);
      @(negedge clk);
      check({tag, "_ready"}, 64'(bus.req_ready), 64'd1);
      bus.req_valid = 1'b1;
      bus.req_op    = op;
      bus.req_addr  = addr;
      @(negedge clk);
      bus.req_valid = 1'b0;
   endtask

   // Wait (bounded) for an L2 request, check it, stall, then accept it
   task automatic l2_serve(input string tag, input logic wr, input logic [31:0] addr, input int stall);
      int k = 0;
      while (!bus.l2_req_valid && k < 20) begin
         @(negedge clk);
         k++;
      end
      check({tag, "_l2v"}, 64'(bus.l2_req_valid), 64'd1);
      check({tag, "_l2wr"}, 64'(bus.l2_req_wr), 64'(wr));
      check({tag, "_l2addr"}, 64'(bus.l2_req_addr), 64'(addr));
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         check({tag, "_stable"}, {31'd0, bus.l2_req_valid, bus.l2_req_wr, bus.l2_req_addr},
               {31'd0, 1'b1, wr, addr});
      end
      bus.l2_req_ready = 1'b1;
      @(negedge clk);
      bus.l2_req_ready = 1'b0;
   endtask

   task automatic resp_now(input string tag, input logic hit, input logic [1:0] way);
      check({tag, "_rv"}, 64'(bus.resp_valid), 64'd1);
      check({tag, "_hit"}, 64'(bus.resp_hit), 64'(hit));
      check({tag, "_way"}, 64'(bus.resp_way), 64'(way));
   endtask

   // Request that finishes without L2 traffic: response exactly 2 cycles after acceptance
   task automatic quick(input string tag, input logic [1:0] op, input logic [31:0] addr,
                        input logic hit, input logic [1:0] way);
      issue(tag, op, addr);
      check({tag, "_nol2a"}, 64'(bus.l2_req_valid), 64'd0);
      @(negedge clk);
      resp_now(tag, hit, way);
      check({tag, "_nol2b"}, 64'(bus.l2_req_valid), 64'd0);
   endtask

   // Miss with optional write-back; response is due 1 cycle after the fill acceptance edge
   task automatic miss(input string tag, input logic [1:0] op, input logic [31:0] addr,
                       input logic do_wb, input logic [31:0] wb_addr, input int wb_stall,
                       input logic [1:0] way);
      issue(tag, op, addr);
      if (do_wb) l2_serve({tag, "_wb"}, 1'b1, wb_addr, wb_stall);
      l2_serve({tag, "_fill"}, 1'b0, {addr[31:6], 6'd0}, 0);
      resp_now(tag, 1'b0, way);
   endtask

   initial begin
      int  busy;
      logic clr_hit;
      bus.req_valid    = 1'b0;
      bus.req_op       = 2'b00;
      bus.req_addr     = '0;
      bus.l2_req_ready = 1'b0;

      repeat (3) @(negedge clk);
      check("rst_ready", 64'(bus.req_ready), 64'd1);
      check("rst_resp", {bus.resp_valid, bus.resp_hit, bus.resp_way}, 64'd0);
      check("rst_l2", {bus.l2_req_valid, bus.l2_req_wr, bus.l2_req_addr}, 64'd0);
      check("rst_stats", {stat_reads, stat_writes} | {stat_hits, stat_misses}, 64'd0);
      rst_n = 1'b1;

      // First read misses into way 0, repeat hits
      miss("rd1047", 2'b00, 32'h0000_1047, 1'b0, 32'h0, 0, 2'd0);
      quick("rd1047_hit", 2'b00, 32'h0000_1047, 1'b1, 2'd0);

      // Fill set 1 with tags 2,3,4; touch tag 1; tag 5 replaces tag 2 (way 1)
      miss("t2", 2'b00, 32'h0000_2040, 1'b0, 32'h0, 0, 2'd1);
      miss("t3", 2'b00, 32'h0000_3040, 1'b0, 32'h0, 0, 2'd2);
      miss("t4", 2'b00, 32'h0000_4040, 1'b0, 32'h0, 0, 2'd3);
      quick("t1_hit", 2'b00, 32'h0000_1040, 1'b1, 2'd0);
      miss("t5", 2'b00, 32'h0000_5040, 1'b0, 32'h0, 0, 2'd1);

      // Dirty tag 1, age it to LRU, then tag 6 forces a stalled write-back
      quick("w1_hit", 2'b01, 32'h0000_1040, 1'b1, 2'd0);
      quick("t3_hit", 2'b00, 32'h0000_3040, 1'b1, 2'd2);
      quick("t4_hit", 2'b00, 32'h0000_4040, 1'b1, 2'd3);
      quick("t5_hit", 2'b00, 32'h0000_5040, 1'b1, 2'd1);
      miss("t6_wb", 2'b00, 32'h0000_6040, 1'b1, 32'h0000_1040, 5, 2'd0);

      // Write-miss tag 1 into way 2 (dirty), evict it with write-back, then it misses again
      miss("w1_miss", 2'b01, 32'h0000_1040, 1'b0, 32'h0, 0, 2'd2);
      issue("ev1040", 2'b10, 32'h0000_1040);
      l2_serve("ev1040_wb", 1'b1, 32'h0000_1040, 0);
      resp_now("ev1040", 1'b1, 2'd2);
      miss("t1_again", 2'b00, 32'h0000_1040, 1'b0, 32'h0, 0, 2'd2);
      quick("ev_absent", 2'b10, 32'h00FF_F040, 1'b0, 2'd0);

      // Clear with 4 valid lines: 64 CLEAR cycles + 1 RESP with req_ready low
      issue("clear", 2'b11, 32'h0);
      busy    = 0;
      clr_hit = 1'b1;
      while (!bus.req_ready && busy < 200) begin
         if (bus.resp_valid) clr_hit = bus.resp_hit;
         busy++;
         @(negedge clk);
      end
      check("clear_busy", 64'(busy), 64'd65);
      check("clear_hit", 64'(clr_hit), 64'd0);
      miss("c6", 2'b00, 32'h0000_6040, 1'b0, 32'h0, 0, 2'd0);
      miss("c5", 2'b00, 32'h0000_5040, 1'b0, 32'h0, 0, 2'd1);
      miss("c1", 2'b00, 32'h0000_1040, 1'b0, 32'h0, 0, 2'd2);
      miss("c4", 2'b00, 32'h0000_4040, 1'b0, 32'h0, 0, 2'd3);
`ifdef L1_CACHE_STATS_EN
      check("st_reads", 64'(stat_reads), 64'd4);
      check("st_writes", 64'(stat_writes), 64'd0);
      check("st_hits", 64'(stat_hits), 64'd0);
      check("st_misses", 64'(stat_misses), 64'd4);
`else
      check("st_off", {stat_reads, stat_writes} | {stat_hits, stat_misses}, 64'd0);
`endif

      // Reset while FILL is outstanding drops the request and never installs the line
      issue("rstfill", 2'b00, 32'h0000_7040);
      busy = 0;
      while (!bus.l2_req_valid && busy < 20) begin
         @(negedge clk);
         busy++;
      end
      check("rstfill_l2", {bus.l2_req_valid, bus.l2_req_wr, bus.l2_req_addr},
            {1'b1, 1'b0, 32'h0000_7040});
      rst_n = 1'b0;
      @(negedge clk);
      check("rstfill_l2v", 64'(bus.l2_req_valid), 64'd0);
      check("rstfill_ready", 64'(bus.req_ready), 64'd1);
      rst_n = 1'b1;
      miss("rstfill_absent", 2'b00, 32'h0000_7040, 1'b0, 32'h0, 0, 2'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
